// File: rtl/mod_sequencer.sv
// Modulation sequencer: steps through the modulation buffer at a programmable rate and
// launches one modulator pass per step, SYNC or duty-set event, serialising overlapping events.
module mod_sequencer #(
    parameter int ADDR_W       = 15,
    parameter int DIV_W        = 16,
    parameter int BRAM_LAT     = 2,
    parameter int DONE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync,
    input  logic              tick,
    input  logic [ADDR_W-1:0] mod_cycle,
    input  logic [DIV_W-1:0]  mod_div,
    input  logic              duty_req,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [7:0]        bram_rdata,
    output logic [7:0]        mod,
    output logic              update,
    input  logic              mod_done,
    output logic [ADDR_W-1:0] idx,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int FC_W = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
    localparam int TO_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BRAM_LAT - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_GUARD     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [DIV_W-1:0]  div_cnt_r, div_nxt_s;
    logic [ADDR_W-1:0] idx_r, idx_nxt_s;
    logic [FC_W-1:0]   fetch_cnt_r, fetch_cnt_nxt_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_nxt_s;
    logic [7:0]        mod_r, mod_nxt_s;
    logic              update_r, update_nxt_s;
    logic              pending_r, pending_nxt_s;
    logic              overrun_r, overrun_nxt_s;
    logic              timeout_r, timeout_nxt_s;
    logic              step_s, event_s, bram_en_s;

    // Rate divider and sequence index; SYNC wins over TICK.
    always_comb begin
        div_nxt_s = div_cnt_r;
        idx_nxt_s = idx_r;
        step_s    = 1'b0;
        if (sync) begin
            div_nxt_s = '0;
            idx_nxt_s = '0;
        end else if (tick) begin
            if (div_cnt_r == mod_div) begin
                step_s    = 1'b1;
                div_nxt_s = '0;
                idx_nxt_s = (idx_r >= mod_cycle) ? '0 : idx_r + ADDR_W'(1);
            end else begin
                div_nxt_s = div_cnt_r + DIV_W'(1);
            end
        end else begin
            div_nxt_s = div_cnt_r;
        end
    end

    assign event_s = sync | step_s | duty_req;

    // Pass sequencing; the read address is the index as updated by this cycle's event.
    always_comb begin
        state_nxt_s     = state_r;
        fetch_cnt_nxt_s = fetch_cnt_r;
        to_cnt_nxt_s    = to_cnt_r;
        mod_nxt_s       = mod_r;
        update_nxt_s    = 1'b0;
        pending_nxt_s   = pending_r;
        overrun_nxt_s   = overrun_r;
        timeout_nxt_s   = timeout_r;
        bram_en_s       = 1'b0;
        if (event_s && pending_r) begin
            overrun_nxt_s = 1'b1;
        end else begin
            overrun_nxt_s = overrun_r;
        end
        if ((state_r != ST_IDLE) && event_s) begin
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (event_s || pending_r) begin
                    bram_en_s       = 1'b1;
                    pending_nxt_s   = 1'b0;
                    fetch_cnt_nxt_s = '0;
                    state_nxt_s     = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (fetch_cnt_r == FC_LAST) begin
                    mod_nxt_s   = bram_rdata;
                    state_nxt_s = ST_LAUNCH;
                end else begin
                    fetch_cnt_nxt_s = fetch_cnt_r + FC_W'(1);
                end
            end
            ST_LAUNCH: begin
                update_nxt_s = 1'b1;
                state_nxt_s  = ST_GUARD;
            end
            ST_GUARD: begin
                to_cnt_nxt_s = '0;
                state_nxt_s  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (mod_done) begin
                    state_nxt_s = ST_IDLE;
                end else if (to_cnt_r == TO_LAST) begin
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    to_cnt_nxt_s = to_cnt_r + TO_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            div_cnt_r   <= '0;
            idx_r       <= '0;
            fetch_cnt_r <= '0;
            to_cnt_r    <= '0;
            mod_r       <= 8'h00;
            update_r    <= 1'b0;
            pending_r   <= 1'b0;
            overrun_r   <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            div_cnt_r   <= div_nxt_s;
            idx_r       <= idx_nxt_s;
            fetch_cnt_r <= fetch_cnt_nxt_s;
            to_cnt_r    <= to_cnt_nxt_s;
            mod_r       <= mod_nxt_s;
            update_r    <= update_nxt_s;
            pending_r   <= pending_nxt_s;
            overrun_r   <= overrun_nxt_s;
            timeout_r   <= timeout_nxt_s;
        end
    end

    assign bram_en     = bram_en_s;
    assign bram_addr   = bram_en_s ? idx_nxt_s : '0;
    assign mod         = mod_r;
    assign update      = update_r;
    assign idx         = idx_r;
    assign busy        = (state_r != ST_IDLE);
    assign overrun     = overrun_r;
    assign timeout_err = timeout_r;

endmodule

// File: tb/tb_mod_sequencer.sv
// Bench for mod_sequencer: BRAM and modulator models, an index model for the expected
// samples, and a scoreboard queue checked on every UPDATE pulse.
module tb_mod_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0, tick = 1'b0, duty_req = 1'b0;
    logic [14:0] mod_cycle = 15'd3;
    logic [15:0] mod_div = 16'd1;
    logic        bram_en, update, busy, overrun, timeout_err;
    logic [14:0] bram_addr, idx;
    logic [7:0]  bram_rdata, mod;
    logic        mod_done;

    int checks = 0, errors = 0, upd_cnt = 0;
    int m_idx = 0, m_div = 0;
    logic hang = 1'b0;
    logic [7:0] q[$];
    logic [7:0] s1 = 8'h00, s2 = 8'h00;
    int done_cnt;

    mod_sequencer dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .tick(tick), .mod_cycle(mod_cycle),
        .mod_div(mod_div), .duty_req(duty_req), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_rdata(bram_rdata), .mod(mod), .update(update), .mod_done(mod_done),
        .idx(idx), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sample(input int a);
        return 8'(((a % 16) + 1) * 10);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Two-cycle BRAM read pipeline.
    always @(posedge clk) begin
        if (bram_en) s1 <= sample(int'(bram_addr));
        s2 <= s1;
    end
    assign bram_rdata = s2;

    // Modulator: drops DONE on UPDATE, raises it 5 cycles later unless hung.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_done <= 1'b1;
            done_cnt <= 0;
        end else if (update) begin
            mod_done <= 1'b0;
            done_cnt <= hang ? 0 : 5;
        end else if (done_cnt != 0) begin
            done_cnt <= done_cnt - 1;
            if (done_cnt == 1) mod_done <= 1'b1;
        end
    end

    // Scoreboard: every UPDATE must present the next expected sample.
    always @(negedge clk) begin
        if (rst_n && update) begin
            upd_cnt++;
            check_eq("sb_nonempty", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) check_eq("sb_mod", mod, q.pop_front());
        end
    end

    task automatic drive(input logic s, input logic t, input logic d, input logic idle_exp);
        logic ev;
        @(posedge clk); #1;
        sync = s; tick = t; duty_req = d;
        ev = s | d | (t && (m_div == int'(mod_div)));
        if (s) begin
            m_div = 0; m_idx = 0;
        end else if (t) begin
            if (m_div == int'(mod_div)) begin
                m_div = 0;
                m_idx = (m_idx >= int'(mod_cycle)) ? 0 : m_idx + 1;
            end else begin
                m_div++;
            end
        end
        if (idle_exp && ev) begin
            #1;
            check_eq("bram_en", bram_en, 1);
            check_eq("bram_addr", bram_addr, m_idx);
            q.push_back(sample(m_idx));
        end
        @(posedge clk); #1;
        sync = 1'b0; tick = 1'b0; duty_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // reset values
        #12;
        check_eq("rst_en", bram_en, 0);
        check_eq("rst_addr", bram_addr, 0);
        check_eq("rst_mod", mod, 0);
        check_eq("rst_upd", update, 0);
        check_eq("rst_idx", idx, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ovr", overrun, 0);
        check_eq("rst_to", timeout_err, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // 1: 8 ticks, MOD_DIV=1 -> 4 steps, samples 20,30,40,10
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            repeat (6) @(posedge clk);
        end
        wait_idle();
        check_eq("t1_updates", upd_cnt, 4);
        check_eq("t1_idx", idx, 0);
        check_eq("t1_ovr", overrun, 0);

        // 2: latency from event to UPDATE
        @(posedge clk); #1;
        duty_req = 1'b1;
        #1;
        check_eq("t2_en_t", bram_en, 1);
        check_eq("t2_addr", bram_addr, m_idx);
        q.push_back(sample(m_idx));
        @(posedge clk); #1;
        duty_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check_eq($sformatf("t2_upd_t%0d", k), update, (k == 4) ? 1 : 0);
            if (k == 1) check_eq("t2_en_off", bram_en, 0);
        end
        wait_idle();

        // 3: two DUTY_REQs during WAIT_DONE -> one extra pass, OVERRUN
        base = upd_cnt;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        q.push_back(sample(m_idx));
        @(negedge clk);
        check_eq("t3_ovr_first", overrun, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("t3_ovr_second", overrun, 1);
        repeat (40) @(posedge clk);
        wait_idle();
        check_eq("t3_passes", upd_cnt - base, 2);

        // 4: SYNC and TICK together at IDX=2 with a non-zero divider count
        mod_div = 16'd0;
        drive(1'b1, 1'b0, 1'b0, 1'b1); wait_idle();
        drive(1'b0, 1'b1, 1'b0, 1'b1); wait_idle();
        drive(1'b0, 1'b1, 1'b0, 1'b1); wait_idle();
        check_eq("t4_idx2", idx, 2);
        mod_div = 16'd1;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t4_idx_hold", idx, 2);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("t4_idx_sync", idx, 0);
        wait_idle();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t4_div_cleared", idx, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t4_step", idx, 1);
        wait_idle();

        // 5: shrink MOD_CYCLE below IDX, then MOD_CYCLE=0
        mod_cycle = 15'd7; mod_div = 16'd0;
        drive(1'b1, 1'b0, 1'b0, 1'b1); wait_idle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1); wait_idle();
        end
        check_eq("t5_idx5", idx, 5);
        mod_cycle = 15'd3;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t5_wrap", idx, 0);
        wait_idle();
        mod_cycle = 15'd0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            check_eq("t5_stuck", idx, 0);
            wait_idle();
        end

        // 6: MOD_DONE held low -> timeout after DONE_TIMEOUT cycles
        hang = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (1015) @(posedge clk);
        @(negedge clk);
        check_eq("t6_to_early", timeout_err, 0);
        check_eq("t6_busy_early", busy, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_eq("t6_to_set", timeout_err, 1);
        check_eq("t6_idle", busy, 0);
        hang = 1'b0;

        // reset in the middle of FETCH
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        #2; rst_n = 1'b0; #1;
        check_eq("mr_en", bram_en, 0);
        check_eq("mr_addr", bram_addr, 0);
        check_eq("mr_mod", mod, 0);
        check_eq("mr_upd", update, 0);
        check_eq("mr_idx", idx, 0);
        check_eq("mr_busy", busy, 0);
        check_eq("mr_ovr", overrun, 0);
        check_eq("mr_to", timeout_err, 0);
        q.delete();
        m_idx = 0; m_div = 0;
        base = upd_cnt;
        repeat (6) @(negedge clk);
        check_eq("mr_no_upd", upd_cnt - base, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // normal pass after reset
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        wait_idle();
        check_eq("post_rst_pass", upd_cnt - base, 1);
        check_eq("sb_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
